field_unpacker: RTL and testbench
=================================

Name: field_unpacker

Overview:
- Receive side of the team's packed-field format. The transmit side concatenates {a[A_W-1:0], b_bit, c_bit} into an (A_W+2)-bit word and sends it serially, MSB first, with a start-of-frame marker.
- This block deserializes that bit stream, checks framing, splits each completed word back into a, b and c, and presents them on a one-entry valid/ready output register with backpressure.

Parameters:
- A_W, 3, width of field a; legal range is A_W >= 1.
- Derived localparam FRAME_W = A_W+2. It is not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- sin_valid  in  1  serial bit qualifier
- sin_bit  in  1  serial data bit, MSB of frame first
- sin_sof  in  1  marks the first bit of a frame; qualified by sin_valid
- sin_ready  out  1  block can accept a bit this cycle (combinational)
- out_a  out  A_W  unpacked field a (frame bits FRAME_W-1..2)
- out_b  out  1  unpacked b bit (frame bit 1)
- out_c  out  1  unpacked c bit (frame bit 0)
- out_valid  out  1  out_a/out_b/out_c hold an unconsumed frame
- out_ready  in  1  consumer accepts the frame
- err_sof  out  1  one-cycle pulse: sin_sof arrived mid-frame
- frame_cnt  out  8  count of completed frames; wraps 255->0

Behaviour:
- Reset (async assert, sync release): state=IDLE, bit count=0, shift register=0; out_a=0, out_b=0, out_c=0, out_valid=0, err_sof=0, frame_cnt=0.
- A bit is accepted only when sin_valid && sin_ready.
- States: IDLE, SHIFT.
- IDLE:
  - Accepted bit with sin_sof=1: becomes frame bit FRAME_W-1; count=1; go to SHIFT.
  - Accepted bit with sin_sof=0: silently discarded; stay in IDLE.
- SHIFT:
  - Accepted bit with sin_sof=0: shifted in; count++.
  - When the accepted bit is the FRAME_W-th bit, that same edge loads the output register: out_a=frame[FRAME_W-1:2], out_b=frame[1], out_c=frame[0]. It also sets out_valid=1, increments frame_cnt, clears count and returns to IDLE.
  - Latency: outputs are valid in the cycle after the last bit is accepted.
- sin_sof=1 on an accepted bit while in SHIFT (any position, including the last):
  - Partial frame discarded.
  - err_sof=1 for exactly one cycle.
  - That bit starts a new frame (count=1, stay in SHIFT).
  - frame_cnt unchanged.
- err_sof is 0 in every other cycle.
- Output handshake:
  - out_valid clears on an edge with out_valid && out_ready, unless a new frame loads on the same edge; in that case out_valid stays 1 with the new data.
  - Outputs are stable while out_valid && !out_ready.
- Backpressure: sin_ready=0 only when all three hold: state=SHIFT, count==FRAME_W-1, and out_valid && !out_ready. Otherwise sin_ready=1, including in IDLE and during reset.
  - sin_ready depends combinationally on out_ready.
  - A stalled final bit is not consumed and must be held by the sender.
- Back-to-back: with out_ready=1 and sin_valid=1 continuously, one frame completes every FRAME_W cycles with no bubbles.
- Reset mid-frame: the partial frame and any pending output are discarded. The first frame after release requires a new sin_sof.

Test Plan:
- Reset: assert rst after 2 bits of a frame -> all outputs 0 immediately (async), sin_ready=1. After release, 3 bits without sof -> out_valid stays 0, frame_cnt=0.
- Single frame (A_W=3): sof + bits 1,0,1,1,0, out_ready=1 -> next cycle out_a=3'b101, out_b=1, out_c=0, out_valid=1 for one cycle; frame_cnt=1.
- Back-to-back: 4 frames (10110, 01101, 11111, 00000), sin_valid continuous, out_ready=1 -> out_valid pulses every 5 cycles with matching fields; frame_cnt=4; err_sof never asserted.
- Backpressure: out_ready=0, frame 10110 completes, then second frame 01101 is sent.
  - Expected: sin_ready=0 while the 5th bit is presented; out_a stays 3'b101.
  - Raise out_ready -> same-edge swap: out_valid stays 1, out_a=3'b011, out_b=0, out_c=1.
- Mid-frame sof: sof + 1,1,0, then sof + 0,0,1,0,1 -> err_sof single pulse after the second sof. Output is out_a=3'b001, out_b=0, out_c=1; frame_cnt increments by 1 only.
- Wrap: 256 consecutive good frames -> frame_cnt returns to 0; the 257th frame gives frame_cnt=1.

Source files
------------

// File: rtl/field_unpacker.sv
// Serial receiver for the packed {a, b, c} field format: deserializes MSB-first
// frames delimited by a start-of-frame marker and holds each result until consumed.
module field_unpacker #(
    parameter int A_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sin_valid,
    input  logic           sin_bit,
    input  logic           sin_sof,
    output logic           sin_ready,
    output logic [A_W-1:0] out_a,
    output logic           out_b,
    output logic           out_c,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           err_sof,
    output logic [7:0]     frame_cnt
);

    localparam int FRAME_W = A_W + 2;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [CNT_W-1:0]     cnt_s;
    logic [FRAME_W-1:0]   shift_r;
    logic [FRAME_W-1:0]   shift_s;
    logic [FRAME_W-1:0]   word_s;
    logic                 accept_s;
    logic                 load_s;
    logic                 err_s;
    logic                 sin_ready_s;
    logic [A_W-1:0]       out_a_r;
    logic                 out_b_r;
    logic                 out_c_r;
    logic                 out_valid_r;
    logic                 err_sof_r;
    logic [7:0]           frame_cnt_r;

    // The last bit stalls only if the held result cannot leave on this same edge.
    assign sin_ready_s = ~((state_r == SHIFT) && (cnt_r == LAST_CNT) &&
                           out_valid_r && ~out_ready);
    assign accept_s    = sin_valid & sin_ready_s;
    assign word_s      = {shift_r[FRAME_W-2:0], sin_bit};

    // Next-state, bit counter and shift register update.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        shift_s = shift_r;
        load_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && sin_sof) begin
                    state_s = SHIFT;
                    cnt_s   = ONE_CNT;
                    shift_s = {{(FRAME_W-1){1'b0}}, sin_bit};
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (accept_s && sin_sof) begin
                    // A marker mid-frame restarts framing from this bit.
                    err_s   = 1'b1;
                    cnt_s   = ONE_CNT;
                    shift_s = {{(FRAME_W-1){1'b0}}, sin_bit};
                end else if (accept_s && (cnt_r == LAST_CNT)) begin
                    load_s  = 1'b1;
                    state_s = IDLE;
                    cnt_s   = '0;
                    shift_s = word_s;
                end else if (accept_s) begin
                    cnt_s   = cnt_r + ONE_CNT;
                    shift_s = word_s;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                shift_s = '0;
            end
        endcase
    end

    // Framing state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            shift_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
        end
    end

    // Output register, error pulse and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a_r     <= '0;
            out_b_r     <= 1'b0;
            out_c_r     <= 1'b0;
            out_valid_r <= 1'b0;
            err_sof_r   <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            err_sof_r <= err_s;
            if (load_s) begin
                out_a_r     <= word_s[FRAME_W-1:2];
                out_b_r     <= word_s[1];
                out_c_r     <= word_s[0];
                out_valid_r <= 1'b1;
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign sin_ready = sin_ready_s;
    assign out_a     = out_a_r;
    assign out_b     = out_b_r;
    assign out_c     = out_c_r;
    assign out_valid = out_valid_r;
    assign err_sof   = err_sof_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_field_unpacker.sv
// Self-checking bench for field_unpacker (A_W=3): frame table plus directed
// reset, backpressure, mid-frame marker and counter wrap sequences.
module tb_field_unpacker;

    logic       clk = 1'b0;
    logic       rst;
    logic       sin_valid;
    logic       sin_bit;
    logic       sin_sof;
    logic       sin_ready;
    logic [2:0] out_a;
    logic       out_b;
    logic       out_c;
    logic       out_valid;
    logic       out_ready;
    logic       err_sof;
    logic [7:0] frame_cnt;

    typedef struct {
        logic [4:0] frame;
        logic [2:0] a;
        logic       b;
        logic       c;
    } vec_t;

    typedef struct {
        logic [2:0] a;
        logic       b;
        logic       c;
    } exp_t;

    vec_t vecs [4];
    exp_t sq [$];
    exp_t mon_e;
    int   chk_cnt    = 0;
    int   pass_cnt   = 0;
    int   err_pulses = 0;

    field_unpacker #(.A_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin_valid (sin_valid),
        .sin_bit   (sin_bit),
        .sin_sof   (sin_sof),
        .sin_ready (sin_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sof   (err_sof),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Inputs change 2 time units after a rising edge; the edge accepts the bit.
    task automatic drive_bit(input logic b, input logic sof);
        sin_valid = 1'b1;
        sin_bit   = b;
        sin_sof   = sof;
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [4:0] f, input logic [2:0] a, input logic b, input logic c);
        exp_t e;
        e.a = a;
        e.b = b;
        e.c = c;
        for (int i = 4; i >= 0; i--) begin
            if (i == 0) sq.push_back(e);
            drive_bit(f[i], (i == 4));
        end
    endtask

    task automatic idle(input int n);
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Scoreboard: every handshaken output must match the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && err_sof) err_pulses++;
        if (!rst && out_valid && out_ready) begin
            if (sq.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sq.pop_front();
                chk("sb_a", 32'(out_a), 32'(mon_e.a));
                chk("sb_b", 32'(out_b), 32'(mon_e.b));
                chk("sb_c", 32'(out_c), 32'(mon_e.c));
            end
        end
    end

    initial begin
        int e0;
        logic [4:0] f;

        vecs[0] = '{5'b10110, 3'b101, 1'b1, 1'b0};
        vecs[1] = '{5'b01101, 3'b011, 1'b0, 1'b1};
        vecs[2] = '{5'b11111, 3'b111, 1'b1, 1'b1};
        vecs[3] = '{5'b00000, 3'b000, 1'b0, 1'b0};

        rst = 1'b1; sin_valid = 1'b0; sin_bit = 1'b0; sin_sof = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(sin_ready), 32'd1);
        chk("rst_cnt",   32'(frame_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Reset mid-frame with a pending, unconsumed output.
        send_frame(5'b10110, 3'b101, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_a",     32'(out_a),     32'd0);
        chk("arst_b",     32'(out_b),     32'd0);
        chk("arst_c",     32'(out_c),     32'd0);
        chk("arst_err",   32'(err_sof),   32'd0);
        chk("arst_cnt",   32'(frame_cnt), 32'd0);
        chk("arst_ready", 32'(sin_ready), 32'd1);
        sq.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
        idle(3);
        chk("post_rst_nosof_valid", 32'(out_valid), 32'd0);
        chk("post_rst_nosof_cnt",   32'(frame_cnt), 32'd0);

        // Single frame, one-cycle valid pulse.
        send_frame(5'b10110, 3'b101, 1'b1, 1'b0);
        sin_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_a",     32'(out_a),     32'd5);
        chk("single_cnt",   32'(frame_cnt), 32'd1);
        idle(1);
        chk("single_valid_drop", 32'(out_valid), 32'd0);

        // Back-to-back frames from the table.
        e0 = err_pulses;
        for (int i = 0; i < 4; i++) send_frame(vecs[i].frame, vecs[i].a, vecs[i].b, vecs[i].c);
        idle(2);
        chk("b2b_cnt", 32'(frame_cnt), 32'd5);
        chk("b2b_err", 32'(err_pulses - e0), 32'd0);

        // Backpressure on the final bit, then same-edge swap.
        out_ready = 1'b0;
        send_frame(5'b10110, 3'b101, 1'b1, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        sin_valid = 1'b1; sin_bit = 1'b1; sin_sof = 1'b0;
        #1;
        chk("bp_ready0", 32'(sin_ready), 32'd0);
        chk("bp_a_hold", 32'(out_a),     32'd5);
        chk("bp_valid",  32'(out_valid), 32'd1);
        @(posedge clk);
        #2;
        chk("bp_ready0_2",  32'(sin_ready), 32'd0);
        chk("bp_a_hold_2",  32'(out_a),     32'd5);
        chk("bp_cnt_stall", 32'(frame_cnt), 32'd6);
        mon_e.a = 3'b011; mon_e.b = 1'b0; mon_e.c = 1'b1;
        sq.push_back(mon_e);
        out_ready = 1'b1;
        #1;
        chk("bp_ready1", 32'(sin_ready), 32'd1);
        @(posedge clk);
        #2;
        sin_valid = 1'b0;
        chk("swap_valid", 32'(out_valid), 32'd1);
        chk("swap_a",     32'(out_a),     32'd3);
        chk("swap_b",     32'(out_b),     32'd0);
        chk("swap_c",     32'(out_c),     32'd1);
        chk("swap_cnt",   32'(frame_cnt), 32'd7);
        idle(2);

        // Marker arriving mid-frame.
        e0 = err_pulses;
        drive_bit(1'b1, 1'b1);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        send_frame(5'b00101, 3'b001, 1'b0, 1'b1);
        idle(3);
        chk("midsof_err_pulses", 32'(err_pulses - e0), 32'd1);
        chk("midsof_cnt",        32'(frame_cnt),       32'd8);

        // Counter wrap from a fresh reset.
        rst = 1'b1;
        #1;
        sq.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            f = 5'($urandom_range(0, 31));
            send_frame(f, f[4:2], f[1], f[0]);
        end
        idle(1);
        chk("wrap_cnt0", 32'(frame_cnt), 32'd0);
        send_frame(5'b11001, 3'b110, 1'b0, 1'b1);
        idle(1);
        chk("wrap_cnt1", 32'(frame_cnt), 32'd1);

        idle(3);
        chk("sb_drained", 32'(sq.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
